// File: rtl/add_round_key.sv
// AES-128 AddRoundKey stage with an on-the-fly key schedule: one 128-bit round
// key is held and the next one is derived in EXP_CYCLES cycles after each use.
module add_round_key #(
  parameter int NR         = 10,
  parameter int EXP_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_key,
  input  logic [127:0]          cipher_key,
  input  logic                  enable,
  input  logic [3:0][3:0][7:0]  state_in_array,
  output logic [3:0][3:0][7:0]  state_output,
  output logic                  done,
  output logic                  key_ready,
  output logic [3:0]            round_out
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    READY    = 2'd1,
    EXPAND   = 2'd2,
    FINISHED = 2'd3
  } fsm_t;

  localparam logic [3:0] LAST_ROUND = 4'(NR);
  localparam logic [1:0] LAST_WORD  = 2'(EXP_CYCLES - 1);

  fsm_t                 state;
  fsm_t                 state_next;
  logic [127:0]         key;
  logic [3:0]           round;
  logic [7:0]           rcon;
  logic [1:0]           k;
  logic                 accept;
  logic [7:0]           sbox_in;
  logic [7:0]           sub_byte;
  logic [31:0]          w0_next;
  logic [31:0]          w1_next;
  logic [31:0]          w2_next;
  logic [31:0]          w3_next;
  logic [127:0]         key_expanded;
  logic [3:0][3:0][7:0] xor_result;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = a;
    for (int i = 0; i < 8; i++) begin
      p = p ^ (b[i] ? t : 8'h00);
      t = xtime(t);
    end
    return p;
  endfunction

  // S-box: multiplicative inverse as a^254 (0 maps to 0), then the affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = a;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  assign accept = (state == READY) && enable && !load_key;

  // Single shared S-box: edge k substitutes byte k of RotWord(w3) into byte k of w0.
  // w3 stays untouched until the last edge, so RotWord(w3) is stable across the sweep,
  // and w1..w3 are chained off the finished w0 on that last edge.
  always_comb begin
    case (k)
      2'd0:    sbox_in = key[23:16];
      2'd1:    sbox_in = key[15:8];
      2'd2:    sbox_in = key[7:0];
      2'd3:    sbox_in = key[31:24];
      default: sbox_in = 8'h00;
    endcase
    sub_byte = sbox(sbox_in);
    w0_next  = key[127:96];
    case (k)
      2'd0:    w0_next[31:24] = key[127:120] ^ sub_byte ^ rcon;
      2'd1:    w0_next[23:16] = key[119:112] ^ sub_byte;
      2'd2:    w0_next[15:8]  = key[111:104] ^ sub_byte;
      2'd3:    w0_next[7:0]   = key[103:96]  ^ sub_byte;
      default: w0_next        = key[127:96];
    endcase
    w1_next = key[95:64] ^ w0_next;
    w2_next = key[63:32] ^ w1_next;
    w3_next = key[31:0]  ^ w2_next;
    if (k == LAST_WORD) begin
      key_expanded = {w0_next, w1_next, w2_next, w3_next};
    end else begin
      key_expanded = {w0_next, key[95:0]};
    end
  end

  // state[r][c] pairs with key byte 4c+r (byte 0 in the MSBs)
  always_comb begin
    xor_result = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        xor_result[r][c] = state_in_array[r][c] ^ key[127 - 8*(4*c + r) -: 8];
      end
    end
  end

  // Next-state logic; load_key takes priority from any state.
  always_comb begin
    state_next = state;
    if (load_key) begin
      state_next = READY;
    end else begin
      case (state)
        IDLE:     state_next = IDLE;
        READY:    begin
          if (enable) begin
            state_next = (round == LAST_ROUND) ? FINISHED : EXPAND;
          end else begin
            state_next = READY;
          end
        end
        EXPAND:   state_next = (k == LAST_WORD) ? READY : EXPAND;
        FINISHED: state_next = FINISHED;
        default:  state_next = IDLE;
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Key schedule registers and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      key          <= 128'h0;
      round        <= 4'd0;
      rcon         <= 8'h01;
      k            <= 2'd0;
      state_output <= '0;
      done         <= 1'b0;
      key_ready    <= 1'b0;
      round_out    <= 4'd0;
    end else begin
      done      <= accept;
      key_ready <= (state_next == READY);
      if (load_key) begin
        key   <= cipher_key;
        round <= 4'd0;
        rcon  <= 8'h01;
        k     <= 2'd0;
      end else if (accept) begin
        state_output <= xor_result;
        round_out    <= round;
        k            <= 2'd0;
      end else if (state == EXPAND) begin
        key <= key_expanded;
        k   <= k + 2'd1;
        if (k == LAST_WORD) begin
          round <= round + 4'd1;
          rcon  <= xtime(rcon);
        end else begin
          round <= round;
        end
      end else begin
        k <= k;
      end
    end
  end

endmodule

// File: tb/tb_add_round_key.sv
// Self-checking bench for add_round_key: FIPS-197 vectors plus randomized keys
// and states checked against a word-level AES-128 key-schedule model.
module tb_add_round_key;

  typedef logic [3:0][3:0][7:0] st_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         load_key;
  logic [127:0] cipher_key;
  logic         enable;
  st_t          state_in_array;
  st_t          state_output;
  logic         done;
  logic         key_ready;
  logic [3:0]   round_out;

  int total = 0;
  int bad   = 0;

  logic [7:0]   sb [0:255];
  logic [127:0] rk [0:10];

  always #5 clk = ~clk;

  add_round_key #(.NR(10), .EXP_CYCLES(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .load_key       (load_key),
    .cipher_key     (cipher_key),
    .enable         (enable),
    .state_in_array (state_in_array),
    .state_output   (state_output),
    .done           (done),
    .key_ready      (key_ready),
    .round_out      (round_out)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic st_t to_arr(input logic [127:0] v);
    st_t a;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        a[r][c] = v[127 - 8*(4*c + r) -: 8];
    return a;
  endfunction

  // S-box from log/antilog tables over generator 3, then the affine map bit by bit
  task automatic build_sbox();
    int ex [0:255];
    int lg [0:255];
    int p, t, inv, s, b;
    p = 1;
    for (int i = 0; i < 255; i++) begin
      ex[i] = p;
      lg[p] = i;
      t = p << 1;
      if (t > 255) t = t ^ 283;
      p = p ^ t;
    end
    for (int x = 0; x < 256; x++) begin
      inv = (x == 0) ? 0 : ex[(255 - lg[x]) % 255];
      s = 0;
      for (int i = 0; i < 8; i++) begin
        b = ((inv >> i) ^ (inv >> ((i + 4) % 8)) ^ (inv >> ((i + 5) % 8)) ^
             (inv >> ((i + 6) % 8)) ^ (inv >> ((i + 7) % 8)) ^ (99 >> i)) & 1;
        s = s | (b << i);
      end
      sb[x] = s[7:0];
    end
  endtask

  // Textbook 44-word key expansion into 11 round keys
  task automatic make_keys(input logic [127:0] ck);
    logic [31:0] w [0:43];
    logic [31:0] t;
    int rc;
    for (int i = 0; i < 4; i++) w[i] = ck[127 - 32*i -: 32];
    rc = 1;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc[7:0], 24'h0};
        rc = rc * 2;
        if (rc > 255) rc = rc ^ 283;
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (key_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    total++;
    if (key_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s_timeout key_ready=%b after %0d cycles, want 1", name, key_ready, n);
    end
  endtask

  task automatic load(input logic [127:0] ck);
    cipher_key = ck;
    load_key = 1'b1;
    tick();
    load_key = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; load_key = 1'b0; enable = 1'b0;
    cipher_key = 128'h0; state_in_array = '0;
    tick(); tick();
    reset = 1'b0;
    total += 4;
    if (state_output !== '0) begin bad++; $display("FAIL reset_state got=%h want=0", state_output); end
    if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    if (key_ready !== 1'b0) begin bad++; $display("FAIL reset_key_ready got=%b want=0", key_ready); end
    if (round_out !== 4'd0) begin bad++; $display("FAIL reset_round got=%0d want=0", round_out); end
  endtask

  task automatic test_fips();
    st_t exp;
    logic [127:0] st;
    make_keys(128'h2b7e151628aed2a6abf7158809cf4f3c);
    load(128'h2b7e151628aed2a6abf7158809cf4f3c);
    total += 2;
    if (key_ready !== 1'b1) begin bad++; $display("FAIL fips_load_ready got=%b want=1", key_ready); end
    if (done !== 1'b0) begin bad++; $display("FAIL fips_load_done got=%b want=0", done); end
    state_in_array = to_arr(128'h3243f6a8885a308d313198a2e0370734);
    enable = 1'b1;
    tick();
    enable = 1'b0;
    exp = to_arr(128'h193de3bea0f4e22b9ac68d2ae9f84808);
    total += 3;
    if (done !== 1'b1) begin bad++; $display("FAIL fips_r0_done got=%b want=1", done); end
    if (round_out !== 4'd0) begin bad++; $display("FAIL fips_r0_round got=%0d want=0", round_out); end
    if (state_output !== exp) begin bad++; $display("FAIL fips_r0_state got=%h want=%h", state_output, exp); end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (key_ready !== 1'b0 || done !== (i == 0)) begin
        bad++; $display("FAIL fips_expand_busy cycle=%0d key_ready=%b done=%b", i, key_ready, done);
      end
      tick();
    end
    total++;
    if (key_ready !== 1'b1) begin bad++; $display("FAIL fips_expand_ready got=%b want=1", key_ready); end
    state_in_array = '0;
    enable = 1'b1;
    tick();
    enable = 1'b0;
    exp = to_arr(128'ha0fafe1788542cb123a339392a6c7605);
    total += 2;
    if (state_output !== exp) begin bad++; $display("FAIL fips_rk1 got=%h want=%h", state_output, exp); end
    if (round_out !== 4'd1) begin bad++; $display("FAIL fips_rk1_round got=%0d want=1", round_out); end
    for (int r = 2; r <= 9; r++) begin
      wait_ready("fips_round");
      st = rand128();
      state_in_array = to_arr(st);
      enable = 1'b1;
      tick();
      enable = 1'b0;
      total += 2;
      if (state_output !== to_arr(st ^ rk[r])) begin
        bad++; $display("FAIL fips_round%0d got=%h want=%h", r, state_output, to_arr(st ^ rk[r]));
      end
      if (round_out !== 4'(r)) begin bad++; $display("FAIL fips_round%0d_idx got=%0d", r, round_out); end
    end
    wait_ready("fips_last");
    state_in_array = to_arr(128'he9317db5cb322c723d2e895faf090794);
    enable = 1'b1;
    tick();
    exp = to_arr(128'h3925841d02dc09fbdc118597196a0b32);
    total += 3;
    if (state_output !== exp) begin bad++; $display("FAIL fips_r10 got=%h want=%h", state_output, exp); end
    if (round_out !== 4'd10) begin bad++; $display("FAIL fips_r10_round got=%0d want=10", round_out); end
    if (done !== 1'b1) begin bad++; $display("FAIL fips_r10_done got=%b want=1", done); end
    // enable stays high in FINISHED: nothing may happen
    for (int i = 0; i < 6; i++) begin
      state_in_array = to_arr(rand128());
      tick();
      total++;
      if (done !== 1'b0 || key_ready !== 1'b0 || state_output !== exp) begin
        bad++; $display("FAIL finished_hold cycle=%0d done=%b key_ready=%b state=%h", i, done, key_ready, state_output);
      end
    end
    enable = 1'b0;
  endtask

  task automatic test_ignored_enable();
    logic [127:0] ck, ck2, st;
    st_t held;
    ck = rand128();
    make_keys(ck);
    load(ck);
    st = rand128();
    state_in_array = to_arr(st);
    enable = 1'b1;
    tick();
    enable = 1'b0;
    held = to_arr(st ^ rk[0]);
    total++;
    if (state_output !== held) begin bad++; $display("FAIL ign_r0 got=%h want=%h", state_output, held); end
    tick();
    enable = 1'b1;
    for (int i = 0; i < 2; i++) begin
      state_in_array = to_arr(rand128());
      tick();
      total++;
      if (done !== 1'b0 || state_output !== held) begin
        bad++; $display("FAIL ign_expand cycle=%0d done=%b state=%h want=%h", i, done, state_output, held);
      end
    end
    enable = 1'b0;
    wait_ready("ign_expand");
    state_in_array = '0;
    enable = 1'b1;
    tick();
    enable = 1'b0;
    total++;
    if (state_output !== to_arr(rk[1]) || round_out !== 4'd1) begin
      bad++; $display("FAIL ign_rk1 got=%h round=%0d want=%h round=1", state_output, round_out, to_arr(rk[1]));
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      state_in_array = to_arr(rand128());
      tick();
      total++;
      if (done !== 1'b0 || state_output !== '0 || key_ready !== 1'b0) begin
        bad++; $display("FAIL ign_idle cycle=%0d done=%b key_ready=%b state=%h", i, done, key_ready, state_output);
      end
    end
    enable = 1'b0;
    load(ck);
    ck2 = rand128();
    cipher_key = ck2;
    load_key = 1'b1;
    enable = 1'b1;
    state_in_array = to_arr(rand128());
    tick();
    load_key = 1'b0;
    enable = 1'b0;
    total++;
    if (done !== 1'b0 || key_ready !== 1'b1 || state_output !== '0) begin
      bad++; $display("FAIL load_beats_enable done=%b key_ready=%b state=%h", done, key_ready, state_output);
    end
    state_in_array = '0;
    enable = 1'b1;
    tick();
    enable = 1'b0;
    total++;
    if (state_output !== to_arr(ck2) || round_out !== 4'd0 || done !== 1'b1) begin
      bad++; $display("FAIL reload_key got=%h round=%0d want=%h round=0", state_output, round_out, to_arr(ck2));
    end
  endtask

  task automatic test_abort();
    logic [127:0] ck, ck2;
    ck = rand128();
    ck2 = rand128();
    load(ck);
    state_in_array = to_arr(rand128());
    enable = 1'b1;
    tick();
    enable = 1'b0;
    tick(); tick();
    load(ck2);
    total++;
    if (key_ready !== 1'b1 || done !== 1'b0) begin
      bad++; $display("FAIL abort_ready key_ready=%b done=%b want 1/0", key_ready, done);
    end
    state_in_array = '0;
    enable = 1'b1;
    tick();
    enable = 1'b0;
    total++;
    if (state_output !== to_arr(ck2) || round_out !== 4'd0 || done !== 1'b1) begin
      bad++; $display("FAIL abort_key got=%h round=%0d want=%h round=0", state_output, round_out, to_arr(ck2));
    end
    make_keys(ck2);
    wait_ready("abort_expand");
    enable = 1'b1;
    tick();
    enable = 1'b0;
    total++;
    if (state_output !== to_arr(rk[1]) || round_out !== 4'd1) begin
      bad++; $display("FAIL abort_rk1 got=%h round=%0d want=%h round=1", state_output, round_out, to_arr(rk[1]));
    end
    tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++;
    if (state_output !== '0 || done !== 1'b0 || key_ready !== 1'b0 || round_out !== 4'd0) begin
      bad++; $display("FAIL reset_mid_expand state=%h done=%b key_ready=%b round=%0d want all 0",
                      state_output, done, key_ready, round_out);
    end
    enable = 1'b1;
    repeat (6) tick();
    enable = 1'b0;
    total++;
    if (key_ready !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL reset_mid_expand_idle key_ready=%b done=%b want 0/0", key_ready, done);
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] ck, applied;
    int exp_round, last_cycle;
    for (int pass = 0; pass < 2; pass++) begin
      ck = rand128();
      make_keys(ck);
      load(ck);
      exp_round = 0;
      last_cycle = 0;
      enable = 1'b1;
      applied = rand128();
      state_in_array = to_arr(applied);
      for (int cyc = 1; cyc <= 70; cyc++) begin
        tick();
        if (done === 1'b1) begin
          total++;
          if (exp_round > 10) begin
            bad++; $display("FAIL b2b_extra_done pass=%0d cycle=%0d", pass, cyc);
          end else if (state_output !== to_arr(applied ^ rk[exp_round]) || round_out !== 4'(exp_round) ||
                       (exp_round > 0 && cyc - last_cycle != 5)) begin
            bad++; $display("FAIL b2b pass=%0d round=%0d got=%h idx=%0d gap=%0d want=%h idx=%0d gap=5",
                            pass, exp_round, state_output, round_out, cyc - last_cycle,
                            to_arr(applied ^ rk[exp_round]), exp_round);
          end
          exp_round++;
          last_cycle = cyc;
        end
        applied = rand128();
        state_in_array = to_arr(applied);
      end
      enable = 1'b0;
      total++;
      if (exp_round != 11) begin bad++; $display("FAIL b2b_count pass=%0d got=%0d want=11", pass, exp_round); end
    end
  endtask

  initial begin
    build_sbox();
    test_reset();
    test_fips();
    test_ignored_enable();
    test_abort();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
